sum_serialiser: RTL and testbench
=================================

// Module: sum_serialiser
//
// PURPOSE
// - Downstream consumer of the adder stage: takes each WIDTH-bit sum plus its overflow flag and streams it out as CHUNK-bit beats.
// - Output uses a valid/ready handshake, so a narrow sink (link, trace port) can drain results at its own rate.
// - Samples offered while a frame is in flight are dropped and counted, never stalled, because the adder produces a result every cycle.
//
// PARAMETERS
// - WIDTH   32  width of in_sum; must be an integer multiple of CHUNK
// - CHUNK    8  beat width on out_data
// - DROP_W  16  width of the saturating dropped-sample counter
// - BEATS = WIDTH/CHUNK (derived localparam); BEATS >= 2
//
// PORTS
// - clk           input   1      clock
// - rst           input   1      reset, asynchronous, active-low
// - in_sum        input   WIDTH  sum from adder
// - in_overflow   input   1      overflow flag accompanying in_sum
// - in_valid      input   1      in_sum/in_overflow valid (tie high behind adder)
// - in_ready      output  1      block accepts a sample this cycle
// - out_data      output  CHUNK  current beat, least-significant chunk first
// - out_overflow  output  1      captured overflow flag, held for whole frame
// - out_last      output  1      final beat of frame
// - out_valid     output  1      beat valid
// - out_ready     input   1      sink accepts beat
// - dropped       output  DROP_W count of samples offered but not accepted, saturating
//
// BEHAVIOUR
// - Reset (rst low, takes effect immediately):
//   - state=IDLE, shift register=0, beat index=0, captured overflow=0, dropped=0.
//   - Therefore out_valid=0, out_data=0, out_overflow=0, out_last=0.
// - FSM states: IDLE, SEND.
//   - IDLE: in_ready=1. If in_valid, capture in_sum into the shift register and in_overflow into the flag, set beat=0, go to SEND.
//   - SEND: out_valid=1, out_data=shift[CHUNK-1:0], out_last=(beat==BEATS-1).
//     - On out_valid && out_ready: shift right by CHUNK, beat++.
//     - Last-beat accept: go to IDLE, or capture again (see back-to-back).
// - Latency: a sample captured at edge N has beat 0 visible on out_valid after edge N (one cycle).
// - Back-to-back: in_ready = IDLE || (SEND && out_last && out_ready).
//   - A capture on the last-beat accept reloads the shift register, resets beat=0 and stays in SEND.
//   - Result: no bubble, BEATS cycles per frame with no backpressure.
//   - in_ready depends combinationally on out_ready; this path is intentional.
// - Backpressure: while out_valid && !out_ready, out_data, out_last and out_overflow hold stable.
// - Drops: each cycle with in_valid && !in_ready increments dropped by 1.
//   - Saturates at all-ones and never wraps.
//   - Only reset clears it.
// - Arithmetic: beat counter is clog2(BEATS) bits. Shift fill is zeros. No width extension of the sum.
// - Reset mid-frame: the frame is abandoned and out_valid drops asynchronously. After release, the next capture starts at beat 0; no partial frame resumes.
// - in_valid during reset: ignored, no capture and no drop count.
//
// STRUCTURE
// - sum_serialiser_pkg:
//   - state_t enum {IDLE, SEND}
//   - function computing BEATS and the beat-counter width
// - Sub-module sat_counter #(WIDTH=DROP_W): increment enable, saturating, async active-low reset. Used for dropped.
// - Remaining logic (FSM, shift register, beat counter) stays inline.
//
// TESTING (WIDTH=32, CHUNK=8, out_ready=1 unless stated)
// 1. Hold rst low with in_valid=1 -> out_valid=0, out_data=0, dropped=0. Release -> capture on first edge.
// 2. in_sum=0x12345678, ovf=0 -> beats 0x78,0x56,0x34,0x12 on consecutive cycles; out_last on 0x12 only.
//    Next sample 0xA5A5A5A5 -> its first beat 0xA5 follows with no gap.
// 3. Drop out_ready for 3 cycles while beat 0x56 is shown -> out_data=0x56, out_valid=1 held; sequence resumes 0x34,0x12.
// 4. Hold in_valid high continuously -> dropped +3 per frame. With DROP_W=2, dropped sticks at 3.
// 5. in_sum=0xFFFFFFFF, ovf=1, then 0x1, ovf=0 -> out_overflow=1 on all 4 beats of frame 1, 0 on all of frame 2.
// 6. Assert rst after beat 0x56 is accepted -> out_valid=0 immediately. After release, new sample 0xDEADBEEF starts at beat 0xEF.

Source files
------------

// File: rtl/sum_serialiser_pkg.sv
// Shared types and sizing helpers for the sum serialiser.
// Beat count and counter width are derived from WIDTH/CHUNK.
package sum_serialiser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic int calc_beats(int w, int c);
    return w / c;
  endfunction

  function automatic int calc_beat_w(int b);
    return (b > 1) ? $clog2(b) : 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable.
// Sticks at all-ones; only reset clears it.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;
  logic             w_full;

  assign w_full  = &r_count;
  assign o_count = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_inc && !w_full) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/sum_serialiser.sv
// Streams each WIDTH-bit sum out as CHUNK-bit beats, LS chunk first.
// Samples arriving mid-frame are dropped and counted, never stalled.
module sum_serialiser
  import sum_serialiser_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CHUNK  = 8,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in_sum,
  input  logic              in_overflow,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CHUNK-1:0]  out_data,
  output logic              out_overflow,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DROP_W-1:0] dropped
);

  localparam int BEATS = calc_beats(WIDTH, CHUNK);
  localparam int BW    = calc_beat_w(BEATS);

  state_t           r_state;
  state_t           w_nstate;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_beat;
  logic             r_ovf;

  logic w_send;
  logic w_last;
  logic w_acc;
  logic w_cap;
  logic w_drop;

  assign w_send = (r_state == SEND);
  assign w_last = w_send && (r_beat == BW'(BEATS - 1));
  assign w_acc  = w_send && out_ready;
  assign w_cap  = in_valid && in_ready;
  assign w_drop = in_valid && !in_ready;

  assign out_valid    = w_send;
  assign out_last     = w_last;
  assign out_data     = w_send ? r_shift[CHUNK-1:0] : '0;
  assign out_overflow = w_send && r_ovf;

  // in_ready follows out_ready on the last beat so frames abut
  always_comb begin
    w_nstate = r_state;
    in_ready = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_nstate = SEND;
      end
      SEND: begin
        in_ready = w_last && out_ready;
        if (w_last && out_ready && !in_valid)
          w_nstate = IDLE;
      end
      default: w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nstate;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
      r_beat  <= '0;
      r_ovf   <= 1'b0;
    end else if (w_cap) begin
      r_shift <= in_sum;
      r_beat  <= '0;
      r_ovf   <= in_overflow;
    end else if (w_acc) begin
      r_shift <= r_shift >> CHUNK;
      r_beat  <= w_last ? '0 : r_beat + BW'(1);
    end
  end

  sat_counter #(
    .WIDTH (DROP_W)
  ) u_drop (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_drop),
    .o_count (dropped)
  );

endmodule

// File: tb/tb_sum_serialiser.sv
// Directed bench for sum_serialiser: framing, backpressure, drops,
// overflow capture and mid-frame reset. A DROP_W=2 copy checks saturation.
module tb_sum_serialiser;

  logic        clk;
  logic        rst;
  logic [31:0] in_sum;
  logic        in_overflow;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_overflow;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dropped;

  logic        in_ready2;
  logic [7:0]  out_data2;
  logic        out_overflow2;
  logic        out_last2;
  logic        out_valid2;
  logic [1:0]  dropped2;

  int n_chk;
  int n_err;

  sum_serialiser #(
    .WIDTH (32), .CHUNK (8), .DROP_W (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_sum       (in_sum),
    .in_overflow  (in_overflow),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_overflow (out_overflow),
    .out_last     (out_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .dropped      (dropped)
  );

  sum_serialiser #(
    .WIDTH (32), .CHUNK (8), .DROP_W (2)
  ) dut2 (
    .clk          (clk),
    .rst          (rst),
    .in_sum       (in_sum),
    .in_overflow  (in_overflow),
    .in_valid     (in_valid),
    .in_ready     (in_ready2),
    .out_data     (out_data2),
    .out_overflow (out_overflow2),
    .out_last     (out_last2),
    .out_valid    (out_valid2),
    .out_ready    (out_ready),
    .dropped      (dropped2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bt(input string tag,
                    input logic [7:0] d,
                    input logic l,
                    input logic o);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".data"}, {24'd0, out_data}, {24'd0, d});
    chk({tag, ".last"}, {31'd0, out_last}, {31'd0, l});
    chk({tag, ".ovf"}, {31'd0, out_overflow}, {31'd0, o});
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  initial begin
    n_chk       = 0;
    n_err       = 0;
    rst         = 1'b0;
    in_valid    = 1'b1;
    in_sum      = 32'h1234_5678;
    in_overflow = 1'b0;
    out_ready   = 1'b1;

    repeat (2) nxt();
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.data", {24'd0, out_data}, 32'd0);
    chk("rst.ovf", {31'd0, out_overflow}, 32'd0);
    chk("rst.last", {31'd0, out_last}, 32'd0);
    chk("rst.drop", {16'd0, dropped}, 32'd0);
    chk("rst.drop2", {30'd0, dropped2}, 32'd0);
    rst = 1'b1;

    // frame 1: 0x12345678, in_valid held high
    nxt(); bt("f1b0", 8'h78, 1'b0, 1'b0);
    chk("f1b0.drop", {16'd0, dropped}, 32'd0);
    in_sum = 32'hA5A5_A5A5;
    nxt(); bt("f1b1", 8'h56, 1'b0, 1'b0);
    chk("f1b1.drop", {16'd0, dropped}, 32'd1);
    nxt(); bt("f1b2", 8'h34, 1'b0, 1'b0);
    nxt(); bt("f1b3", 8'h12, 1'b1, 1'b0);
    chk("f1b3.rdy", {31'd0, in_ready}, 32'd1);
    chk("f1b3.drop", {16'd0, dropped}, 32'd3);
    chk("f1b3.drop2", {30'd0, dropped2}, 32'd3);

    // frame 2 follows with no bubble
    nxt(); bt("f2b0", 8'hA5, 1'b0, 1'b0);
    chk("f2b0.rdy", {31'd0, in_ready}, 32'd0);
    in_sum = 32'h1234_5678;
    nxt(); bt("f2b1", 8'hA5, 1'b0, 1'b0);
    chk("f2b1.drop", {16'd0, dropped}, 32'd4);
    chk("f2b1.sat2", {30'd0, dropped2}, 32'd3);
    nxt(); bt("f2b2", 8'hA5, 1'b0, 1'b0);
    nxt(); bt("f2b3", 8'hA5, 1'b1, 1'b0);
    chk("f2b3.drop", {16'd0, dropped}, 32'd6);

    // frame 3: stall three cycles on 0x56
    nxt(); bt("f3b0", 8'h78, 1'b0, 1'b0);
    in_sum      = 32'hFFFF_FFFF;
    in_overflow = 1'b1;
    nxt(); bt("f3b1", 8'h56, 1'b0, 1'b0);
    out_ready = 1'b0;
    #1;
    chk("f3.stall.rdy", {31'd0, in_ready}, 32'd0);
    repeat (3) begin
      nxt(); bt("f3.hold", 8'h56, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    nxt(); bt("f3b2", 8'h34, 1'b0, 1'b0);
    nxt(); bt("f3b3", 8'h12, 1'b1, 1'b0);
    chk("f3b3.drop", {16'd0, dropped}, 32'd12);
    chk("f3b3.drop2", {30'd0, dropped2}, 32'd3);

    // frame 4: overflow set on all beats
    nxt(); bt("f4b0", 8'hFF, 1'b0, 1'b1);
    in_sum      = 32'h0000_0001;
    in_overflow = 1'b0;
    nxt(); bt("f4b1", 8'hFF, 1'b0, 1'b1);
    nxt(); bt("f4b2", 8'hFF, 1'b0, 1'b1);
    nxt(); bt("f4b3", 8'hFF, 1'b1, 1'b1);

    // frame 5: overflow clear, zero fill
    nxt(); bt("f5b0", 8'h01, 1'b0, 1'b0);
    in_sum = 32'h1234_5678;
    nxt(); bt("f5b1", 8'h00, 1'b0, 1'b0);
    nxt(); bt("f5b2", 8'h00, 1'b0, 1'b0);
    nxt(); bt("f5b3", 8'h00, 1'b1, 1'b0);

    // frame 6: reset after 0x56 accepted
    nxt(); bt("f6b0", 8'h78, 1'b0, 1'b0);
    nxt(); bt("f6b1", 8'h56, 1'b0, 1'b0);
    nxt(); bt("f6b2", 8'h34, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("mrst.valid", {31'd0, out_valid}, 32'd0);
    chk("mrst.data", {24'd0, out_data}, 32'd0);
    chk("mrst.ovf", {31'd0, out_overflow}, 32'd0);
    chk("mrst.drop", {16'd0, dropped}, 32'd0);
    in_sum = 32'hDEAD_BEEF;
    nxt();
    chk("mrst.hold.valid", {31'd0, out_valid}, 32'd0);
    chk("mrst.hold.drop", {16'd0, dropped}, 32'd0);
    rst = 1'b1;

    nxt(); bt("f7b0", 8'hEF, 1'b0, 1'b0);
    in_valid = 1'b0;
    nxt(); bt("f7b1", 8'hBE, 1'b0, 1'b0);
    nxt(); bt("f7b2", 8'hAD, 1'b0, 1'b0);
    nxt(); bt("f7b3", 8'hDE, 1'b1, 1'b0);
    chk("f7b3.drop", {16'd0, dropped}, 32'd0);
    nxt();
    chk("idle.valid", {31'd0, out_valid}, 32'd0);
    chk("idle.rdy", {31'd0, in_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
